// File: rtl/board_io_pkg.sv
// Shared types and defaults for the board input path.
//   rst_state_t       : processor reset sequencer states (IDLE / HOLD / STRETCH)
//   DEBOUNCE_DEFAULT  : stable samples required before a pin change is accepted (10 ms @100 MHz)
//   RST_HOLD_DEFAULT  : cycles proc_rst is stretched after the reset source goes away
package board_io_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        STRETCH = 2'd2
    } rst_state_t;

    localparam int DEBOUNCE_DEFAULT = 1_000_000;
    localparam int RST_HOLD_DEFAULT = 16;

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchronizer followed by a debouncer for a WIDTH-bit channel.
// The whole bus is treated as one channel: any bit differing from the accepted
// value keeps the counter running, and all bits are accepted together.
//   clk0  : sampling clock
//   rst0  : asynchronous active-low reset
//   din   : raw, asynchronous input
//   dout  : debounced value
//   rise  : one-cycle pulse when bit 0 of dout goes 0 -> 1
module io_debounce #(
    parameter int WIDTH = 1,
    parameter int N     = 4
) (
    input  logic             clk0,
    input  logic             rst0,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             rise
);

    localparam int            CW       = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] stable_reg;
    logic [CW-1:0]    cnt_reg;
    logic             rise_reg;

    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            sync1_reg  <= '0;
            sync2_reg  <= '0;
            stable_reg <= '0;
            cnt_reg    <= '0;
            rise_reg   <= 1'b0;
        end else begin
            sync1_reg <= din;
            sync2_reg <= sync1_reg;
            rise_reg  <= 1'b0;
            if (sync2_reg != stable_reg) begin
                // A change that keeps drifting while counting still counts as
                // "different"; whatever is on the synchronizer at the last count wins.
                if (cnt_reg == CNT_LAST) begin
                    stable_reg <= sync2_reg;
                    cnt_reg    <= '0;
                    rise_reg   <= sync2_reg[0] & ~stable_reg[0];
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end else begin
                // Returned to the accepted value before the count completed: glitch.
                cnt_reg <= '0;
            end
        end
    end

    assign dout = stable_reg;
    assign rise = rise_reg;

endmodule

// File: rtl/board_input_conditioner.sv
// Conditions raw board pins into the processor's reset, run-enable and switch inputs.
//   clk0     : CLK100MHZ
//   rst0     : asynchronous active-low reset of this block
//   btnL     : raw button, press = processor reset
//   btnR     : raw button, press = toggle run enable
//   sw_in    : raw switches
//   proc_rst : active-high reset to the processor, held and then stretched
//   proc_en  : run enable to the processor
//   sw_out   : debounced switch bus
module board_input_conditioner
    import board_io_pkg::*;
#(
    parameter int   SW_WIDTH        = 16,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int   RST_HOLD        = RST_HOLD_DEFAULT,
    parameter logic EN_INIT         = 1'b1
) (
    input  logic                clk0,
    input  logic                rst0,
    input  logic                btnL,
    input  logic                btnR,
    input  logic [SW_WIDTH-1:0] sw_in,
    output logic                proc_rst,
    output logic                proc_en,
    output logic [SW_WIDTH-1:0] sw_out
);

    localparam int            HW        = $clog2(RST_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

    logic          bl_stable;
    logic          br_rise;
    logic          bl_rise_unused;
    logic          br_stable_unused;
    logic          sw_rise_unused;

    rst_state_t    state_reg, state_next;
    logic [HW-1:0] hold_reg, hold_next;
    logic          proc_rst_reg;
    logic          en_reg, en_next;

    io_debounce #(.WIDTH(1), .N(DEBOUNCE_CYCLES)) u_db_btnl (
        .clk0 (clk0),
        .rst0 (rst0),
        .din  (btnL),
        .dout (bl_stable),
        .rise (bl_rise_unused)
    );

    io_debounce #(.WIDTH(1), .N(DEBOUNCE_CYCLES)) u_db_btnr (
        .clk0 (clk0),
        .rst0 (rst0),
        .din  (btnR),
        .dout (br_stable_unused),
        .rise (br_rise)
    );

    io_debounce #(.WIDTH(SW_WIDTH), .N(DEBOUNCE_CYCLES)) u_db_sw (
        .clk0 (clk0),
        .rst0 (rst0),
        .din  (sw_in),
        .dout (sw_out),
        .rise (sw_rise_unused)
    );

    // Reset sequencer: HOLD while the button is down, then STRETCH for RST_HOLD cycles.
    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        case (state_reg)
            IDLE: begin
                if (bl_stable) state_next = HOLD;
            end
            HOLD: begin
                if (!bl_stable) begin
                    state_next = STRETCH;
                    hold_next  = '0;
                end
            end
            STRETCH: begin
                if (bl_stable) begin
                    state_next = HOLD;
                end else if (hold_reg == HOLD_LAST) begin
                    state_next = IDLE;
                end else begin
                    hold_next = hold_reg + HW'(1);
                end
            end
            default: begin
                state_next = STRETCH;
                hold_next  = '0;
            end
        endcase
    end

    // The enable only toggles from IDLE as currently registered, so a press that
    // lands on the cycle the stretch ends is dropped rather than queued.
    always_comb begin
        en_next = en_reg;
        if (state_reg != IDLE) begin
            en_next = EN_INIT;
        end else if (br_rise) begin
            en_next = ~en_reg;
        end
    end

    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            state_reg    <= STRETCH;
            hold_reg     <= '0;
            proc_rst_reg <= 1'b1;
            en_reg       <= EN_INIT;
        end else begin
            state_reg    <= state_next;
            hold_reg     <= hold_next;
            proc_rst_reg <= (state_next != IDLE);
            en_reg       <= en_next;
        end
    end

    assign proc_rst = proc_rst_reg;
    assign proc_en  = en_reg;

endmodule
